// File: rtl/owl_ctrl.sv
// One-wire interconnect line controller: pulse-width-coded byte transmit and
// receive over an open-drain pad, clocked from HCLK.
module owl_ctrl #(
    parameter int CNT_W  = 8,
    parameter int T_SLOT = 64,
    parameter int T_LOW1 = 8,
    parameter int T_LOW0 = 40,
    parameter int T_THR  = 24,
    parameter int T_TMO  = 128
) (
    input  logic       HCLK,
    input  logic       RESETN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_col,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    input  logic       OWLI,
    output logic       OWLO,
    output logic       OWL_POE,
    output logic       OWL_NOE,
    output logic       OWL_PU,
    output logic       OWL_PD,
    output logic       OWL_IE
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_LOW    = 3'd1,
        TX_REL    = 3'd2,
        RX_LOW    = 3'd3,
        RX_REL    = 3'd4,
        RX_WAITHI = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SLOT = CNT_W'(T_SLOT);
    localparam logic [CNT_W-1:0] C_LOW1 = CNT_W'(T_LOW1);
    localparam logic [CNT_W-1:0] C_LOW0 = CNT_W'(T_LOW0);
    localparam logic [CNT_W-1:0] C_THR  = CNT_W'(T_THR);
    localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(T_TMO);
    // Released line is only visible through the synchroniser 3 cycles later.
    localparam logic [CNT_W-1:0] C_GUARD = CNT_W'(3);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + C_ONE;
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       tx_byte_r;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_data_r;
    logic             tx_ready_r;
    logic             busy_r;
    logic             noe_r;
    logic             tx_col_r;
    logic             rx_valid_r;
    logic             rx_err_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;

    logic             fall_s;
    logic             rise_s;
    logic             dec_s;
    logic [CNT_W-1:0] low_len_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign fall_s    = prev_r & ~sync2_r;
    assign rise_s    = ~prev_r & sync2_r;
    assign dec_s     = (cnt_r < C_THR);
    assign low_len_s = tx_byte_r[idx_r] ? C_LOW1 : C_LOW0;
    assign cnt_inc_s = sat_inc(cnt_r);

    // Two-flop synchroniser for the pad input plus the edge-detect history flop.
    always_ff @(posedge HCLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= OWLI;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Line protocol FSM with all control outputs registered.
    always_ff @(posedge HCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            idx_r      <= 3'd0;
            tx_byte_r  <= 8'h00;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            noe_r      <= 1'b0;
            tx_col_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            tx_col_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            noe_r      <= 1'b0;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r    <= RX_LOW;
                        cnt_r      <= C_ONE;
                        idx_r      <= 3'd0;
                        rx_shift_r <= 8'h00;
                    end else if (tx_valid && tx_ready_r) begin
                        state_r   <= TX_LOW;
                        tx_byte_r <= tx_data;
                        idx_r     <= 3'd0;
                        cnt_r     <= C_ONE;
                        noe_r     <= 1'b1;
                    end else begin
                        cnt_r      <= '0;
                        tx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                TX_LOW: begin
                    cnt_r <= cnt_inc_s;
                    if (cnt_r >= low_len_s) begin
                        state_r <= TX_REL;
                    end else begin
                        noe_r <= 1'b1;
                    end
                end
                TX_REL: begin
                    if (!sync2_r && (cnt_r >= low_len_s + C_GUARD)) begin
                        tx_col_r <= 1'b1;
                        state_r  <= RX_WAITHI;
                    end else if (cnt_r >= C_SLOT) begin
                        if (idx_r != 3'd7) begin
                            idx_r   <= idx_r + 3'd1;
                            cnt_r   <= C_ONE;
                            noe_r   <= 1'b1;
                            state_r <= TX_LOW;
                        end else begin
                            state_r    <= IDLE;
                            tx_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                RX_LOW: begin
                    if (rise_s) begin
                        rx_shift_r[idx_r] <= dec_s;
                        if (idx_r == 3'd7) begin
                            rx_data_r  <= {dec_s, rx_shift_r[6:0]};
                            rx_valid_r <= 1'b1;
                            state_r    <= IDLE;
                            tx_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            cnt_r   <= C_ONE;
                            state_r <= RX_REL;
                        end
                    end else if (cnt_r >= C_SLOT) begin
                        rx_err_r <= 1'b1;
                        state_r  <= RX_WAITHI;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                RX_REL: begin
                    if (fall_s) begin
                        cnt_r   <= C_ONE;
                        state_r <= RX_LOW;
                    end else if (cnt_r >= C_TMO) begin
                        rx_err_r   <= 1'b1;
                        state_r    <= IDLE;
                        tx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                RX_WAITHI: begin
                    if (sync2_r) begin
                        state_r    <= IDLE;
                        tx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_r;
    assign tx_col   = tx_col_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;
    assign busy     = busy_r;
    assign OWL_NOE  = noe_r;
    assign OWLO     = 1'b0;
    assign OWL_POE  = 1'b0;
    assign OWL_PD   = 1'b0;
    assign OWL_PU   = 1'b1;
    assign OWL_IE   = 1'b1;

endmodule

// File: tb/tb_owl_ctrl.sv
// Directed bench for owl_ctrl: the line is a wired-AND of the controller's
// pull-down and a bench-side remote pull-down.
module tb_owl_ctrl;

    logic       HCLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ext_low = 1'b0;
    logic       tx_ready, tx_col, rx_valid, rx_err, busy;
    logic [7:0] rx_data;
    logic       OWLO, OWL_POE, OWL_NOE, OWL_PU, OWL_PD, OWL_IE;
    wire        owli_line;

    assign owli_line = ~(OWL_NOE | ext_low);

    owl_ctrl dut (
        .HCLK(HCLK), .RESETN(RESETN),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_col(tx_col),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy),
        .OWLI(owli_line), .OWLO(OWLO), .OWL_POE(OWL_POE), .OWL_NOE(OWL_NOE),
        .OWL_PU(OWL_PU), .OWL_PD(OWL_PD), .OWL_IE(OWL_IE)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int rxv_n, rxe_n, col_n, rxv_cyc, rxe_cyc, col_cyc, acc_cyc, rise_cyc, mark, lowc;
    logic [7:0] rxv_data;
    logic noe_prev = 1'b0;
    int noe_run;
    int noe_lens[$];
    int noe_starts[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(negedge HCLK);
        cyc++;
        if (rx_valid) begin rxv_n++; rxv_cyc = cyc; rxv_data = rx_data; end
        if (rx_err) begin rxe_n++; rxe_cyc = cyc; end
        if (tx_col) begin col_n++; col_cyc = cyc; end
        if (OWL_NOE) begin
            if (!noe_prev) begin
                noe_run = 0;
                noe_starts.push_back(cyc);
                if (tx_valid) begin tx_valid = 1'b0; acc_cyc = cyc; end
            end
            noe_run++;
        end else if (noe_prev) begin
            noe_lens.push_back(noe_run);
        end
        noe_prev = OWL_NOE;
    endtask

    task automatic clear_stats;
        rxv_n = 0; rxe_n = 0; col_n = 0;
        rxv_cyc = 0; rxe_cyc = 0; col_cyc = 0; acc_cyc = 0;
        noe_lens.delete();
        noe_starts.delete();
    endtask

    task automatic rx_bit(input logic b, input int pre);
        int l;
        l = b ? 10 : 38;
        ext_low = 1'b1;
        repeat (l - pre) tick;
        ext_low = 1'b0;
        rise_cyc = cyc;
        repeat (64 - l) tick;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!tx_ready && n < 700) begin tick; n++; end
        check_eq(tag, tx_ready, 1'b1);
    endtask

    task automatic check_tx_pulses(input logic [7:0] b, input int base, input string tag);
        check_eq({tag, "_npulse"}, noe_lens.size(), base + 8);
        if (noe_lens.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                check_eq({tag, "_len"}, noe_lens[base + i], b[i] ? 8 : 40);
                check_eq({tag, "_start"}, noe_starts[base + i] - noe_starts[base], i * 64);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        repeat (3) tick;
        check_eq("rst_pad", {OWLO, OWL_POE, OWL_NOE, OWL_PU, OWL_PD, OWL_IE}, 6'b000101);
        check_eq("rst_ctl", {tx_ready, busy, tx_col, rx_valid, rx_err}, 5'b00000);
        check_eq("rst_rxdata", rx_data, 8'h00);
        RESETN = 1'b1;
        tick;
        check_eq("ready_after_rst", {tx_ready, busy}, 2'b10);

        // TX 0xA5
        clear_stats();
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick;
        check_eq("a5_accept", {tx_valid, tx_ready, busy, OWL_NOE}, 4'b0011);
        lowc = tx_ready ? 0 : 1;
        while (!tx_ready && lowc < 700) begin tick; if (!tx_ready) lowc++; end
        check_eq("a5_ready_low", lowc, 512);
        repeat (4) tick;
        check_tx_pulses(8'hA5, 0, "a5");
        check_eq("a5_col", col_n, 0);
        check_eq("a5_idle", {busy, tx_ready}, 2'b01);

        // RX 0x3C
        clear_stats();
        for (int i = 0; i < 8; i++) rx_bit(((8'h3C >> i) & 8'h01) != 8'h00, 0);
        check_eq("3c_nvalid", rxv_n, 1);
        check_eq("3c_data", rxv_data, 8'h3C);
        check_eq("3c_rxdata", rx_data, 8'h3C);
        check_eq("3c_lat_ok", (rxv_cyc - rise_cyc >= 2) && (rxv_cyc - rise_cyc <= 4), 1'b1);
        check_eq("3c_err", rxe_n, 0);
        check_eq("3c_busy", busy, 1'b0);

        // RX 3 bits then idle-high timeout
        clear_stats();
        rx_bit(1'b1, 0); rx_bit(1'b0, 0); rx_bit(1'b1, 0);
        repeat (200) tick;
        check_eq("tmo_nerr", rxe_n, 1);
        check_eq("tmo_at_ok", (rxe_cyc - rise_cyc >= 126) && (rxe_cyc - rise_cyc <= 136), 1'b1);
        check_eq("tmo_nvalid", rxv_n, 0);
        check_eq("tmo_rxdata", rx_data, 8'h3C);
        check_eq("tmo_busy", busy, 1'b0);

        // RX low held too long
        clear_stats();
        ext_low = 1'b1; mark = cyc;
        repeat (100) tick;
        check_eq("long_nerr", rxe_n, 1);
        check_eq("long_at_ok", (rxe_cyc - mark >= 64) && (rxe_cyc - mark <= 70), 1'b1);
        check_eq("long_busy", {busy, tx_ready}, 2'b10);
        ext_low = 1'b0;
        repeat (5) tick;
        check_eq("long_release", {busy, tx_ready}, 2'b01);
        check_eq("long_nvalid", rxv_n, 0);

        // TX 0xFF with collision 20 cycles into slot 0
        clear_stats();
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick;
        repeat (19) tick;
        ext_low = 1'b1; mark = cyc;
        tx_data = 8'h81; tx_valid = 1'b1;
        repeat (30) tick;
        check_eq("col_n", col_n, 1);
        check_eq("col_at_ok", (col_cyc - mark >= 2) && (col_cyc - mark <= 4), 1'b1);
        check_eq("col_noe", OWL_NOE, 1'b0);
        check_eq("col_held", {tx_valid, tx_ready, busy}, 3'b101);
        check_eq("col_npulse", noe_lens.size(), 1);
        ext_low = 1'b0; mark = cyc;
        for (int n = 0; n < 10 && tx_valid; n++) tick;
        check_eq("col_retry_ok", (acc_cyc - mark >= 3) && (acc_cyc - mark <= 6), 1'b1);
        wait_ready("col_retry_done");
        check_tx_pulses(8'h81, 1, "x81");
        check_eq("x81_col", col_n, 1);

        // tx_valid coincident with a synced falling edge
        clear_stats();
        ext_low = 1'b1;
        tick; tick;
        tx_data = 8'h5A; tx_valid = 1'b1;
        tick;
        check_eq("race_state", {busy, tx_ready, tx_valid, OWL_NOE}, 4'b1010);
        rx_bit(1'b1, 3);
        for (int i = 1; i < 8; i++) rx_bit(((8'hC3 >> i) & 8'h01) != 8'h00, 0);
        wait_ready("race_tx_done");
        check_eq("race_rx", {rxv_n[7:0], rxv_data}, {8'd1, 8'hC3});
        check_eq("race_order", acc_cyc > rxv_cyc, 1'b1);
        check_tx_pulses(8'h5A, 0, "x5a");
        check_eq("race_err", {rxe_n[3:0], col_n[3:0]}, 8'h00);

        // Reset in the middle of a TX low pulse
        tx_data = 8'h00; tx_valid = 1'b1;
        repeat (5) tick;
        check_eq("mid_noe_on", OWL_NOE, 1'b1);
        RESETN = 1'b0;
        #1;
        check_eq("mid_rst", {OWL_NOE, busy, tx_ready, rx_err, rx_data}, {4'b0000, 8'h00});
        repeat (2) tick;
        RESETN = 1'b1;
        tick;
        check_eq("mid_after", {tx_ready, busy, OWL_NOE}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
